adder_pipe: RTL and testbench
=============================

// Module: adder_pipe
// PURPOSE
//  Pipelined two-operand add/subtract unit with valid/ready joins on both operand channels and the result channel.
//  Successor to the combinational adder: registered, STAGES-deep, stallable without bubbles, per-transaction op select.
//  Sits between independent operand producers and one result consumer in the datapath.
// PARAMETERS
//  DATA_IN_WIDTH  8  operand width W; result is W+1 bits
//  STAGES         2  pipeline depth (>=1); accept-to-out_valid latency in cycles when unstalled
// PORTS
//  clk_i       in   1                      clock, all state on rising edge
//  arst_n      in   1                      asynchronous active-low reset
//  in_A        in   W                      operand A
//  in_A_valid  in   1                      A valid
//  in_A_ready  out  1                      A ready
//  in_B        in   W                      operand B
//  in_op       in   1                      0=ADD, 1=SUB; sampled with B
//  in_B_valid  in   1                      B valid
//  in_B_ready  out  1                      B ready
//  out         out  W+1                    result
//  out_valid   out  1                      result valid
//  out_ready   in   1                      consumer ready
//  count_o     out  $clog2(STAGES+1)       occupied stages
// BEHAVIOUR
//  - Reset (arst_n=0, async): all stage valids=0, stage data=0. out=0, out_valid=0, count_o=0, in_*_ready=0.
//  - Join: accept = in_A_valid & in_B_valid & s0_free.
//    in_A_ready = in_B_valid & s0_free; in_B_ready = in_A_valid & s0_free.
//    An input's ready never depends on its own valid.
//  - Stage k advances when it holds valid data and stage k+1 is empty or advancing. Last stage advances on out_ready.
//    s0_free = ~v0 | advance0 (combinational ready chain). Full throughput: 1 txn/cycle when out_ready=1.
//  - Stage 0 computes, zero-extending both operands to W+1 bits:
//    ADD: r = A + B; r[W] = carry.
//    SUB: r = A - B mod 2^(W+1); r[W] = borrow (A<B).
//    Stages 1..STAGES-1 are pure delay.
//  - out/out_valid driven directly from last stage registers. Data held stable while out_valid & ~out_ready.
//  - Bubbles compress: with out_ready=0, younger entries advance into empty stages until the pipe is full.
//    With STAGES full and out_ready=0: in_*_ready=0.
//  - count_o: +1 on accept, -1 on out_valid&out_ready, unchanged when both occur in the same cycle. Range 0..STAGES.
//  - One operand valid without the other: no accept, no state change.
//  - Reset mid-operation discards all in-flight results; no partial output.
// CONFIGURATION
//  ADDER_PIPE_SAT_EN defined: stage 0 clamps r[W-1:0]. ADD carry -> all ones; SUB borrow -> zero. r[W] still reports carry/borrow.
//  ADDER_PIPE_SAT_EN undefined: wrap-around result as above. Timing and handshake are identical in both builds.
// STRUCTURE
//  adder_pipe_pkg:
//   - typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} op_e
//   - function add_sub(a, b, op) returning W+1 bits, with SAT behaviour under ADDER_PIPE_SAT_EN
//  Sub-module adder_pipe_stage:
//   - One valid/ready register slice (valid flop, data flop, ready_o = ~valid | ready_i)
//   - Instantiated STAGES times in a generate loop
//  Top level holds: join logic, stage-0 compute, count_o counter.
// TESTING (W=8, STAGES=2 unless noted)
//  1. A=200, B=100, ADD, out_ready=1 -> out_valid 2 cycles after accept, out=9'h12C (carry=1).
//  2. A=5, B=9, SUB -> out=9'h1FC (borrow=1).
//     Rebuild with ADDER_PIPE_SAT_EN: out=9'h100; ADD 200+100 -> 9'h1FF.
//  3. Back-to-back stream of 10 txns, out_ready=1 -> 1 result/cycle, results in order, count_o steady at 2.
//  4. out_ready=0 after 1 accept, bubble in stage 1 -> second txn accepted, then in_*_ready=0, count_o=2.
//     Release out_ready -> both results drain in order, out stable while stalled.
//  5. in_A_valid=1, in_B_valid=0 for 5 cycles -> in_B_ready=1, in_A_ready=0, no accept, count_o=0.
//     Raise B -> single accept.
//  6. Assert arst_n=0 with pipe full -> out_valid=0, count_o=0 immediately.
//     After release, next txn returns the correct result with no stale output.

Source files
------------

// File: rtl/adder_pipe_pkg.sv
// Shared types and the stage-0 add/subtract helper for adder_pipe.
// Define ADDER_PIPE_SAT_EN to clamp the low W bits on carry/borrow.
package adder_pipe_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int unsigned MAX_W = 64;
    localparam int unsigned IDX_W = $clog2(MAX_W + 1);

    // Operands arrive zero-extended to MAX_W; only bits [w:0] of the result are meaningful.
    function automatic logic [MAX_W:0] add_sub(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input op_e              op,
        input logic [IDX_W-1:0] w
    );
        logic [MAX_W:0] one;
        logic [MAX_W:0] lo_mask;
        logic [MAX_W:0] keep_mask;
        logic [MAX_W:0] r;
`ifdef ADDER_PIPE_SAT_EN
        logic           flag;
`endif
        one       = {{MAX_W{1'b0}}, 1'b1};
        lo_mask   = (one << w) - one;
        keep_mask = (lo_mask << 1) | one;
        if (op == OP_SUB) begin
            r = {1'b0, a} - {1'b0, b};
        end else begin
            r = {1'b0, a} + {1'b0, b};
        end
`ifdef ADDER_PIPE_SAT_EN
        flag = r[w];
`endif
        r = r & keep_mask;
`ifdef ADDER_PIPE_SAT_EN
        // Bit w keeps reporting carry/borrow; only the data bits clamp.
        if (flag) begin
            r = (op == OP_ADD) ? (r | lo_mask) : (r & ~lo_mask);
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One valid/ready register slice; ready passes back combinationally so
// an occupied slice can still accept while its content moves on.
module adder_pipe_stage
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             arst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign ready_o = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Data only loads on a real transfer so a stalled slice holds its value.
    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract with joined operand channels and a stallable result channel.
// Optional build macro: ADDER_PIPE_SAT_EN (saturating result data bits).
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int DATA_IN_WIDTH = 8,
    parameter int STAGES        = 2
) (
    input  logic                         clk_i,
    input  logic                         arst_n,
    input  logic [DATA_IN_WIDTH-1:0]     in_A,
    input  logic                         in_A_valid,
    output logic                         in_A_ready,
    input  logic [DATA_IN_WIDTH-1:0]     in_B,
    input  logic                         in_op,
    input  logic                         in_B_valid,
    output logic                         in_B_ready,
    output logic [DATA_IN_WIDTH:0]       out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(STAGES+1)-1:0]  count_o
);

    localparam int RW = DATA_IN_WIDTH + 1;
    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES:0] valid_c;
    logic [STAGES:0] ready_c;
    logic [RW-1:0]   data_c [STAGES+1];
    logic            s0_free;
    logic            accept;
    logic            out_fire;
    logic [CW-1:0]   count_q;

    // Readies are forced low while reset is asserted, even though the slices look empty.
    assign s0_free    = ready_c[0] & arst_n;
    assign accept     = in_A_valid & in_B_valid & s0_free;
    assign in_A_ready = in_B_valid & s0_free;
    assign in_B_ready = in_A_valid & s0_free;

    assign valid_c[0] = accept;
    assign data_c[0]  = RW'(add_sub(MAX_W'(in_A), MAX_W'(in_B), op_e'(in_op),
                                    IDX_W'(DATA_IN_WIDTH)));
    assign ready_c[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH (RW)
        ) u_stage (
            .clk_i   (clk_i),
            .arst_n  (arst_n),
            .valid_i (valid_c[k]),
            .data_i  (data_c[k]),
            .ready_o (ready_c[k]),
            .valid_o (valid_c[k+1]),
            .data_o  (data_c[k+1]),
            .ready_i (ready_c[k+1])
        );
    end

    assign out       = data_c[STAGES];
    assign out_valid = valid_c[STAGES];
    assign out_fire  = out_valid & out_ready;
    assign count_o   = count_q;

    // Occupancy: simultaneous accept and drain cancel out.
    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            count_q <= '0;
        end else begin
            case ({accept, out_fire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe (W=8, STAGES=2); expectations follow ADDER_PIPE_SAT_EN.
module tb_adder_pipe;
    import adder_pipe_pkg::*;

    localparam int W  = 8;
    localparam int ST = 2;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W:0]   wrap;
        logic [W:0]   sat;
    } vec_t;

    logic         clk_i = 1'b0;
    logic         arst_n = 1'b0;
    logic [W-1:0] in_A = '0;
    logic         in_A_valid = 1'b0;
    logic         in_A_ready;
    logic [W-1:0] in_B = '0;
    logic         in_op = 1'b0;
    logic         in_B_valid = 1'b0;
    logic         in_B_ready;
    logic [W:0]   out;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [1:0]   count_o;

    logic [W:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int seen = 0;
    int cycle = 0;
    vec_t stream_vecs [10];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cycle++;

    adder_pipe #(
        .DATA_IN_WIDTH (W),
        .STAGES        (ST)
    ) dut (
        .clk_i      (clk_i),
        .arst_n     (arst_n),
        .in_A       (in_A),
        .in_A_valid (in_A_valid),
        .in_A_ready (in_A_ready),
        .in_B       (in_B),
        .in_op      (in_op),
        .in_B_valid (in_B_valid),
        .in_B_ready (in_B_ready),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count_o    (count_o)
    );

    function automatic logic [W:0] pick(input logic [W:0] wrap_v, input logic [W:0] sat_v);
`ifdef ADDER_PIPE_SAT_EN
        return sat_v;
`else
        return wrap_v;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed result handshake is matched against the oldest expectation.
    always @(negedge clk_i) begin
        if (arst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got %0h expected none", out);
            end else begin
                checkOutput("result", 32'(out), 32'(exp_q.pop_front()));
            end
            seen++;
        end
    end

    // Called just after a rising edge; returns just after the edge that took the operands.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                                 input logic [W:0] exp, output int cnt);
        in_A = a;
        in_B = b;
        in_op = op;
        in_A_valid = 1'b1;
        in_B_valid = 1'b1;
        cnt = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (in_A_ready && in_B_ready) begin
                exp_q.push_back(exp);
                pushed++;
                cnt = int'(count_o);
                break;
            end
            @(posedge clk_i);
            #1;
        end
        if (cnt < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept");
        end else begin
            @(posedge clk_i);
            #1;
        end
        in_A_valid = 1'b0;
        in_B_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 50; i++) begin
            if (seen == pushed) break;
            @(posedge clk_i);
            #1;
        end
        checkOutput("drain", 32'(seen), 32'(pushed));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int start;
        stream_vecs[0] = '{8'd10,  8'd20,  1'b0, 9'h01E, 9'h01E};
        stream_vecs[1] = '{8'd255, 8'd1,   1'b0, 9'h100, 9'h1FF};
        stream_vecs[2] = '{8'd255, 8'd255, 1'b0, 9'h1FE, 9'h1FF};
        stream_vecs[3] = '{8'd0,   8'd0,   1'b1, 9'h000, 9'h000};
        stream_vecs[4] = '{8'd0,   8'd1,   1'b1, 9'h1FF, 9'h100};
        stream_vecs[5] = '{8'd128, 8'd127, 1'b1, 9'h001, 9'h001};
        stream_vecs[6] = '{8'd127, 8'd128, 1'b1, 9'h1FF, 9'h100};
        stream_vecs[7] = '{8'd100, 8'd50,  1'b1, 9'h032, 9'h032};
        stream_vecs[8] = '{8'd0,   8'd255, 1'b0, 9'h0FF, 9'h0FF};
        stream_vecs[9] = '{8'd1,   8'd255, 1'b1, 9'h102, 9'h100};

        // Reset state, with both valids high to prove readies stay low.
        in_A_valid = 1'b1;
        in_B_valid = 1'b1;
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out", 32'(out), 0);
        checkOutput("rst_count", 32'(count_o), 0);
        checkOutput("rst_a_ready", 32'(in_A_ready), 0);
        checkOutput("rst_b_ready", 32'(in_B_ready), 0);
        in_A_valid = 1'b0;
        in_B_valid = 1'b0;
        @(posedge clk_i);
        #1;
        arst_n = 1'b1;
        @(posedge clk_i);
        #1;

        // Latency: result appears two cycles after the accept cycle.
        applyStimulus(8'd200, 8'd100, OP_ADD, pick(9'h12C, 9'h1FF), c);
        @(negedge clk_i);
        checkOutput("lat_c1_valid", 32'(out_valid), 0);
        @(negedge clk_i);
        checkOutput("lat_c2_valid", 32'(out_valid), 1);
        @(posedge clk_i);
        #1;
        waitDrain();

        applyStimulus(8'd5, 8'd9, OP_SUB, pick(9'h1FC, 9'h100), c);
        waitDrain();

        // Back-to-back stream.
        start = cycle;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(stream_vecs[i].a, stream_vecs[i].b, stream_vecs[i].op,
                          pick(stream_vecs[i].wrap, stream_vecs[i].sat), c);
            checkOutput("stream_count", 32'(c), (i < 2) ? 32'(i) : 32'd2);
        end
        checkOutput("stream_cycles", 32'(cycle - start), 32'd10);
        waitDrain();

        // Stall with bubble compression.
        out_ready = 1'b0;
        applyStimulus(8'd10, 8'd20, OP_ADD, 9'h01E, c);
        checkOutput("stall_cnt_t1", 32'(c), 0);
        applyStimulus(8'd100, 8'd50, OP_SUB, 9'h032, c);
        checkOutput("stall_cnt_t2", 32'(c), 1);
        in_A = 8'd255;
        in_B = 8'd1;
        in_op = OP_ADD;
        in_A_valid = 1'b1;
        in_B_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput("full_a_ready", 32'(in_A_ready), 0);
            checkOutput("full_b_ready", 32'(in_B_ready), 0);
            checkOutput("full_count", 32'(count_o), 2);
            checkOutput("full_out_valid", 32'(out_valid), 1);
            checkOutput("full_out_stable", 32'(out), 32'h01E);
        end
        @(posedge clk_i);
        #1;
        out_ready = 1'b1;
        applyStimulus(8'd255, 8'd1, OP_ADD, pick(9'h100, 9'h1FF), c);
        waitDrain();

        // One operand alone never transfers.
        in_A = 8'd7;
        in_A_valid = 1'b1;
        in_B_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checkOutput("lone_a_ready", 32'(in_A_ready), 0);
            checkOutput("lone_b_ready", 32'(in_B_ready), 1);
            checkOutput("lone_count", 32'(count_o), 0);
            @(posedge clk_i);
            #1;
        end
        applyStimulus(8'd7, 8'd3, OP_SUB, 9'h004, c);
        checkOutput("lone_then_join_cnt", 32'(c), 0);
        waitDrain();
        @(negedge clk_i);
        checkOutput("idle_count", 32'(count_o), 0);
        @(posedge clk_i);
        #1;

        // Reset with the pipe full discards everything in flight.
        out_ready = 1'b0;
        applyStimulus(8'd1, 8'd2, OP_ADD, 9'h003, c);
        applyStimulus(8'd3, 8'd4, OP_ADD, 9'h007, c);
        in_A_valid = 1'b1;
        in_B_valid = 1'b1;
        #3;
        arst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 0);
        checkOutput("midrst_count", 32'(count_o), 0);
        checkOutput("midrst_a_ready", 32'(in_A_ready), 0);
        exp_q.delete();
        pushed = seen;
        in_A_valid = 1'b0;
        in_B_valid = 1'b0;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        arst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk_i);
        #1;
        applyStimulus(8'd128, 8'd127, OP_SUB, 9'h001, c);
        checkOutput("post_rst_cnt", 32'(c), 0);
        waitDrain();
        checkOutput("queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
